// File: rtl/branch_predict_unit_pkg.sv
// Purpose: shared jump opcodes, pipe flush masks, default widths and counter helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package branch_predict_unit_pkg;

    localparam int BPU_ADDR_WIDTH = 16;
    localparam int BPU_JUMP_BITS  = 6;
    localparam int NUM_PIPE_MASKS = 5;

    // Jump opcodes as produced by decode.
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_NOP = 6'd0;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_J   = 6'd1;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JR  = 6'd2;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JEQ = 6'd3;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JNE = 6'd4;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JZ  = 6'd5;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JNZ = 6'd6;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JL  = 6'd7;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JLE = 6'd8;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JG  = 6'd9;
    localparam logic [BPU_JUMP_BITS-1:0] JMP_OP_JGE = 6'd10;

    // One bit per pipeline register that can be squashed.
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 5'b00001;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 5'b00010;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 5'b00100;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 5'b01000;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_MEM_WB = 5'b10000;

    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_FLUSH_FULL =
        PIPE_REG_EX_MEM | PIPE_REG_ID_EX | PIPE_REG_IF_ID | PIPE_REG_PC;

    typedef enum logic [1:0] {
        JC_NONE,
        JC_J,
        JC_JR,
        JC_COND
    } jclass_e;

    function automatic jclass_e jop_class(input logic [BPU_JUMP_BITS-1:0] op);
        jclass_e c;
        c = JC_NONE;
        if (op == JMP_OP_J) begin
            c = JC_J;
        end else if (op == JMP_OP_JR) begin
            c = JC_JR;
        end else if (op >= JMP_OP_JEQ && op <= JMP_OP_JGE) begin
            c = JC_COND;
        end
        return c;
    endfunction

    // Counter encodings: MSB set means predict taken.
    function automatic int ctr_weak_taken(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int ctr_strong_taken(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb_table.sv
// Purpose: BTB storage {valid, tag, target, ctr}; lookup/training reads, one write port.
// Latency: reads combinational, write visible the cycle after wr_en_i.
// Backpressure: none; writes always accepted.
// Ports: clk/reset (async active-low); rd_* fetch lookup; trn_* EX read-back for
//        read-modify-write of the counter; wr_* single write port.
module btb_table
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int BTB_DEPTH  = 16,
    parameter int CTR_BITS   = 2,
    localparam int IDX_W     = $clog2(BTB_DEPTH),
    localparam int TAG_W     = ADDR_WIDTH - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [ADDR_WIDTH-1:0] rd_target_o,
    output logic [CTR_BITS-1:0]   rd_ctr_o,
    input  logic [IDX_W-1:0]      trn_idx_i,
    output logic                  trn_valid_o,
    output logic [TAG_W-1:0]      trn_tag_o,
    output logic [ADDR_WIDTH-1:0] trn_target_o,
    output logic [CTR_BITS-1:0]   trn_ctr_o,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i,
    input  logic [CTR_BITS-1:0]   wr_ctr_i
);

    logic                  valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
    logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];
    logic [CTR_BITS-1:0]   ctr_q    [BTB_DEPTH];

    // No write bypass: a read of the index being written returns the old entry.
    assign rd_valid_o   = valid_q[rd_idx_i];
    assign rd_tag_o     = tag_q[rd_idx_i];
    assign rd_target_o  = target_q[rd_idx_i];
    assign rd_ctr_o     = ctr_q[rd_idx_i];

    assign trn_valid_o  = valid_q[trn_idx_i];
    assign trn_tag_o    = tag_q[trn_idx_i];
    assign trn_target_o = target_q[trn_idx_i];
    assign trn_ctr_o    = ctr_q[trn_idx_i];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i]  <= 1'b1;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i]    <= wr_ctr_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Purpose: fetch-time BTB prediction, EX-stage jump resolution/redirect and BTB training.
// Latency: prediction and resolution combinational; training visible next cycle.
// Backpressure: none; ex_valid qualifies the EX instruction, updates never stall.
// Ports: pc -> take_branch/branch_predict; EX inputs -> flush/jump_address.
// Optional: define BPU_STATS_EN to add saturating stat_branches/stat_mispredicts outputs.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = BPU_ADDR_WIDTH,
    parameter int BTB_DEPTH  = 16,
    parameter int CTR_BITS   = 2,
    parameter int JUMP_BITS  = BPU_JUMP_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     pc,
    output logic [ADDR_WIDTH-1:0]     branch_predict,
    output logic                      take_branch,
    input  logic                      ex_valid,
    input  logic [JUMP_BITS-1:0]      jop,
    input  logic                      zero,
    input  logic                      less,
    input  logic                      greater,
    input  logic [ADDR_WIDTH-1:0]     id_ex_pc,
    input  logic [ADDR_WIDTH-1:0]     id_ex_reg_address,
    input  logic [ADDR_WIDTH-1:0]     id_ex_imm_address,
    input  logic                      branch_taken,
    input  logic [ADDR_WIDTH-1:0]     branch_taken_address,
    output logic [NUM_PIPE_MASKS-1:0] flush,
    output logic [ADDR_WIDTH-1:0]     jump_address
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]               stat_branches,
    output logic [31:0]               stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam logic [CTR_BITS-1:0] CTR_WEAK   = CTR_BITS'(ctr_weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_STRONG = CTR_BITS'(ctr_strong_taken(CTR_BITS));

    logic                  lk_valid, trn_valid;
    logic [TAG_W-1:0]      lk_tag, trn_tag;
    logic [ADDR_WIDTH-1:0] lk_target, trn_target;
    logic [CTR_BITS-1:0]   lk_ctr, trn_ctr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_target;
    logic [CTR_BITS-1:0]   wr_ctr;

    btb_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BTB_DEPTH  (BTB_DEPTH),
        .CTR_BITS   (CTR_BITS)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .rd_idx_i     (pc[IDX_W-1:0]),
        .rd_valid_o   (lk_valid),
        .rd_tag_o     (lk_tag),
        .rd_target_o  (lk_target),
        .rd_ctr_o     (lk_ctr),
        .trn_idx_i    (id_ex_pc[IDX_W-1:0]),
        .trn_valid_o  (trn_valid),
        .trn_tag_o    (trn_tag),
        .trn_target_o (trn_target),
        .trn_ctr_o    (trn_ctr),
        .wr_en_i      (wr_en),
        .wr_idx_i     (id_ex_pc[IDX_W-1:0]),
        .wr_tag_i     (id_ex_pc[ADDR_WIDTH-1:IDX_W]),
        .wr_target_i  (wr_target),
        .wr_ctr_i     (wr_ctr)
    );

    // Fetch-side prediction.
    assign take_branch    = lk_valid && (lk_tag == pc[ADDR_WIDTH-1:IDX_W]) && lk_ctr[CTR_BITS-1];
    assign branch_predict = take_branch ? lk_target : '0;

    // EX-side decode and resolution.
    jclass_e               jc;
    logic                  cond_met, taken, mispredict, is_branch, trn_hit;
    logic [ADDR_WIDTH-1:0] actual_tgt, pc_next;

    assign jc = jop_class(BPU_JUMP_BITS'(jop));

    always_comb begin
        cond_met = 1'b0;
        case (BPU_JUMP_BITS'(jop))
            JMP_OP_JEQ, JMP_OP_JZ:  cond_met = zero;
            JMP_OP_JNE, JMP_OP_JNZ: cond_met = !zero;
            JMP_OP_JL:              cond_met = less;
            JMP_OP_JLE:             cond_met = less | zero;
            JMP_OP_JG:              cond_met = greater;
            JMP_OP_JGE:             cond_met = greater | zero;
            default:                cond_met = 1'b0;
        endcase
    end

    assign is_branch  = (jc == JC_COND) || (jc == JC_JR);
    assign taken      = (jc == JC_JR) || cond_met;
    assign actual_tgt = (jc == JC_JR) ? id_ex_reg_address : id_ex_imm_address;
    assign pc_next    = id_ex_pc + ADDR_WIDTH'(1);
    assign mispredict = is_branch &&
                        ((taken != branch_taken) || (taken && branch_taken_address != actual_tgt));

    // Redirect outputs are held at zero while reset (active-low) is asserted.
    always_comb begin
        flush        = '0;
        jump_address = '0;
        if (reset && ex_valid) begin
            if (jc == JC_J) begin
                flush        = PIPE_REG_EX_MEM;
                jump_address = id_ex_imm_address;
            end else if (is_branch) begin
                if (mispredict) begin
                    flush        = PIPE_FLUSH_FULL;
                    jump_address = taken ? actual_tgt : pc_next;
                end else if (taken) begin
                    flush        = PIPE_REG_EX_MEM;
                    jump_address = actual_tgt;
                end else begin
                    jump_address = pc_next;
                end
            end
        end
    end

    // Training: read-modify-write of the entry at the EX PC's index.
    assign trn_hit = trn_valid && (trn_tag == id_ex_pc[ADDR_WIDTH-1:IDX_W]);

    always_comb begin
        wr_en     = 1'b0;
        wr_target = trn_target;
        wr_ctr    = trn_ctr;
        if (ex_valid && is_branch) begin
            if (trn_hit) begin
                wr_en = 1'b1;
                if (jc == JC_JR) begin
                    wr_target = actual_tgt;
                    wr_ctr    = CTR_STRONG;
                end else if (taken) begin
                    wr_target = actual_tgt;
                    wr_ctr    = (trn_ctr == CTR_STRONG) ? trn_ctr : trn_ctr + CTR_BITS'(1);
                end else begin
                    wr_ctr    = (trn_ctr == '0) ? trn_ctr : trn_ctr - CTR_BITS'(1);
                end
            end else if (taken) begin
                // Allocate, or replace an aliasing entry with a different tag.
                wr_en     = 1'b1;
                wr_target = actual_tgt;
                wr_ctr    = (jc == JC_JR) ? CTR_STRONG : CTR_WEAK;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (ex_valid && is_branch) begin
            if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
            if (mispredict && stat_mis_q != '1) stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Purpose: directed table-driven check of prediction, resolution, training and reset.
// Latency: inputs driven on negedge, outputs sampled 2 time units later.
// Backpressure: n/a.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] branch_predict;
    logic        take_branch;
    logic        ex_valid;
    logic [5:0]  jop;
    logic        zero, less, greater;
    logic [15:0] id_ex_pc, id_ex_reg_address, id_ex_imm_address;
    logic        branch_taken;
    logic [15:0] branch_taken_address;
    logic [4:0]  flush;
    logic [15:0] jump_address;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_predict_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .pc                   (pc),
        .branch_predict       (branch_predict),
        .take_branch          (take_branch),
        .ex_valid             (ex_valid),
        .jop                  (jop),
        .zero                 (zero),
        .less                 (less),
        .greater              (greater),
        .id_ex_pc             (id_ex_pc),
        .id_ex_reg_address    (id_ex_reg_address),
        .id_ex_imm_address    (id_ex_imm_address),
        .branch_taken         (branch_taken),
        .branch_taken_address (branch_taken_address),
        .flush                (flush),
        .jump_address         (jump_address)
`ifdef BPU_STATS_EN
        ,
        .stat_branches        (stat_branches),
        .stat_mispredicts     (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        ev;
        logic [5:0]  jop;
        logic        z, l, g;
        logic [15:0] expc, rega, imm;
        logic        bt;
        logic [15:0] bta;
        logic        etb;
        logic [15:0] ebp;
        logic [4:0]  efl;
        logic [15:0] eja;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    localparam logic [4:0] FL_F = 5'h0F;
    localparam logic [4:0] FL_E = 5'h08;

    function automatic vec_t mk(input logic [15:0] p, input logic ev, input logic [5:0] op,
                                input logic z, input logic l, input logic g,
                                input logic [15:0] expc, input logic [15:0] rega,
                                input logic [15:0] imm, input logic bt, input logic [15:0] bta,
                                input logic etb, input logic [15:0] ebp,
                                input logic [4:0] efl, input logic [15:0] eja);
        vec_t v;
        v.pc = p; v.ev = ev; v.jop = op; v.z = z; v.l = l; v.g = g;
        v.expc = expc; v.rega = rega; v.imm = imm; v.bt = bt; v.bta = bta;
        v.etb = etb; v.ebp = ebp; v.efl = efl; v.eja = eja;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle(input logic [15:0] p);
        pc = p; ex_valid = 1'b0; jop = JMP_OP_NOP; zero = 1'b0; less = 1'b0; greater = 1'b0;
        id_ex_pc = '0; id_ex_reg_address = '0; id_ex_imm_address = '0;
        branch_taken = 1'b0; branch_taken_address = '0;
    endtask

    initial begin
        //                pc     ev op          z  l  g  expc    reg     imm     bt bta     etb ebp     efl   eja
        // JNE train from empty, then decay to strongly-not-taken and check saturation.
        vecs[0]  = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[1]  = mk(16'h0010,1,JMP_OP_JNE,0,0,0,16'h0010,16'h0000,16'h0040,0,16'h0000, 0,16'h0000,FL_F,16'h0040);
        vecs[2]  = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 1,16'h0040,5'h0,16'h0000);
        vecs[3]  = mk(16'h0010,1,JMP_OP_JNE,1,0,0,16'h0010,16'h0000,16'h0040,1,16'h0040, 1,16'h0040,FL_F,16'h0011);
        vecs[4]  = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[5]  = mk(16'h0010,1,JMP_OP_JNE,1,0,0,16'h0010,16'h0000,16'h0040,0,16'h0000, 0,16'h0000,5'h0,16'h0011);
        vecs[6]  = mk(16'h0010,1,JMP_OP_JNE,1,0,0,16'h0010,16'h0000,16'h0040,0,16'h0000, 0,16'h0000,5'h0,16'h0011);
        vecs[7]  = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[8]  = mk(16'h0010,1,JMP_OP_JNE,0,0,0,16'h0010,16'h0000,16'h0040,0,16'h0000, 0,16'h0000,FL_F,16'h0040);
        vecs[9]  = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[10] = mk(16'h0010,1,JMP_OP_JNE,0,0,0,16'h0010,16'h0000,16'h0040,0,16'h0000, 0,16'h0000,FL_F,16'h0040);
        vecs[11] = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 1,16'h0040,5'h0,16'h0000);
        // Aliasing at index 0; same-cycle lookup sees the pre-update entry.
        vecs[12] = mk(16'h0010,1,JMP_OP_JEQ,1,0,0,16'h0110,16'h0000,16'h0080,0,16'h0000, 1,16'h0040,FL_F,16'h0080);
        vecs[13] = mk(16'h0010,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[14] = mk(16'h0110,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 1,16'h0080,5'h0,16'h0000);
        // JR: wrong target, correct target, then hit with a new target.
        vecs[15] = mk(16'h0020,1,JMP_OP_JR, 0,0,0,16'h0020,16'h0200,16'h0000,1,16'h0100, 0,16'h0000,FL_F,16'h0200);
        vecs[16] = mk(16'h0020,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 1,16'h0200,5'h0,16'h0000);
        vecs[17] = mk(16'h0020,1,JMP_OP_JR, 0,0,0,16'h0020,16'h0200,16'h0000,1,16'h0200, 1,16'h0200,FL_E,16'h0200);
        vecs[18] = mk(16'h0020,1,JMP_OP_JR, 0,0,0,16'h0020,16'h0300,16'h0000,1,16'h0200, 1,16'h0200,FL_F,16'h0300);
        vecs[19] = mk(16'h0020,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 1,16'h0300,5'h0,16'h0000);
        // Unconditional J: no training.
        vecs[20] = mk(16'h0030,1,JMP_OP_J,  0,0,0,16'h0030,16'h0000,16'h0555,0,16'h0000, 0,16'h0000,FL_E,16'h0555);
        vecs[21] = mk(16'h0030,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        // JLE/JGE on zero, ex_valid=0, JL not taken, JG taken, PC wrap, NOP in EX.
        vecs[22] = mk(16'h0042,1,JMP_OP_JLE,1,0,0,16'h0042,16'h0000,16'h0044,1,16'h0044, 0,16'h0000,FL_E,16'h0044);
        vecs[23] = mk(16'h0042,1,JMP_OP_JGE,1,0,0,16'h0043,16'h0000,16'h0050,0,16'h0000, 1,16'h0044,FL_F,16'h0050);
        vecs[24] = mk(16'h0045,0,JMP_OP_JEQ,1,0,0,16'h0045,16'h0000,16'h0060,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[25] = mk(16'h0045,0,JMP_OP_NOP,0,0,0,16'h0000,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);
        vecs[26] = mk(16'h0043,1,JMP_OP_JL, 1,0,0,16'h0046,16'h0000,16'h0070,0,16'h0000, 1,16'h0050,5'h0,16'h0047);
        vecs[27] = mk(16'h0047,1,JMP_OP_JG, 0,0,1,16'h0047,16'h0000,16'h0099,1,16'h0099, 0,16'h0000,FL_E,16'h0099);
        vecs[28] = mk(16'h0047,1,JMP_OP_JEQ,0,0,0,16'hFFFF,16'h0000,16'h1234,1,16'h1234, 1,16'h0099,FL_F,16'h0000);
        vecs[29] = mk(16'h0010,1,JMP_OP_NOP,0,0,0,16'h0050,16'h0000,16'h0000,0,16'h0000, 0,16'h0000,5'h0,16'h0000);

        // Reset held low with a J in EX: redirect outputs must stay zero.
        reset = 1'b0;
        drive_idle(16'h0010);
        ex_valid = 1'b1; jop = JMP_OP_J; id_ex_imm_address = 16'h0555;
        #2;
        check("rst take_branch", 32'(take_branch), 32'd0);
        check("rst branch_predict", 32'(branch_predict), 32'd0);
        check("rst flush", 32'(flush), 32'd0);
        check("rst jump_address", 32'(jump_address), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pc = vecs[i].pc; ex_valid = vecs[i].ev; jop = vecs[i].jop;
            zero = vecs[i].z; less = vecs[i].l; greater = vecs[i].g;
            id_ex_pc = vecs[i].expc; id_ex_reg_address = vecs[i].rega;
            id_ex_imm_address = vecs[i].imm; branch_taken = vecs[i].bt;
            branch_taken_address = vecs[i].bta;
            if (vecs[i].ev && (vecs[i].jop == JMP_OP_JR ||
                (vecs[i].jop >= JMP_OP_JEQ && vecs[i].jop <= JMP_OP_JGE))) begin
                exp_br++;
                if (vecs[i].efl == FL_F) exp_mis++;
            end
            #2;
            check($sformatf("v%0d take_branch", i), 32'(take_branch), 32'(vecs[i].etb));
            check($sformatf("v%0d branch_predict", i), 32'(branch_predict), 32'(vecs[i].ebp));
            check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].efl));
            check($sformatf("v%0d jump_address", i), 32'(jump_address), 32'(vecs[i].eja));
        end

        // Reset mid-run with a populated table.
        @(negedge clk);
        drive_idle(16'h0020);
        #2;
        check("pre-reset hit 0x0020", 32'(take_branch), 32'd1);
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, 32'(exp_br));
        check("stat_mispredicts", stat_mispredicts, 32'(exp_mis));
`endif
        ex_valid = 1'b1; jop = JMP_OP_J; id_ex_pc = 16'h0030; id_ex_imm_address = 16'h0555;
        #1;
        reset = 1'b0;
        #1;
        check("mid-rst take_branch", 32'(take_branch), 32'd0);
        check("mid-rst branch_predict", 32'(branch_predict), 32'd0);
        check("mid-rst flush", 32'(flush), 32'd0);
        check("mid-rst jump_address", 32'(jump_address), 32'd0);
`ifdef BPU_STATS_EN
        check("mid-rst stat_branches", stat_branches, 32'd0);
        check("mid-rst stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_idle(16'h0000);
        begin
            logic [15:0] probe [6];
            probe[0] = 16'h0020; probe[1] = 16'h0110; probe[2] = 16'h0042;
            probe[3] = 16'h0043; probe[4] = 16'h0047; probe[5] = 16'h0010;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                pc = probe[k];
                #2;
                check($sformatf("post-rst miss %h", probe[k]), 32'(take_branch), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
